// File: rtl/systolic_tile_sequencer_if.sv
`default_nettype none
// ============================================================================
// systolic_tile_sequencer_if -- command, array-control and drain-handshake bus
// Rev 1.0
// ============================================================================
interface systolic_tile_sequencer_if #(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int K_MAX = 256
);
   localparam int ROW_W  = ($clog2(ROWS) < 1) ? 1 : $clog2(ROWS);
   localparam int COL_W  = ($clog2(COLS) < 1) ? 1 : $clog2(COLS);
   localparam int ADDR_W = ($clog2(K_MAX) < 1) ? 1 : $clog2(K_MAX);
   localparam int KLEN_W = ($clog2(K_MAX + 1) < 1) ? 1 : $clog2(K_MAX + 1);

   logic              start_i;
   logic              abort_i;
   logic [KLEN_W-1:0] k_len_i;
   logic              out_ready_i;

   logic              busy_o;
   logic              done_o;
   logic              err_o;
   logic              w_load_o;
   logic [ROW_W-1:0]  w_row_o;
   logic              acc_clr_o;
   logic              a_rd_en_o;
   logic [ADDR_W-1:0] a_addr_o;
   logic              a_zero_o;
   logic              pe_en_o;
   logic              out_valid_o;
   logic [COL_W-1:0]  drain_col_o;

   modport master (
      output start_i, abort_i, k_len_i, out_ready_i,
      input  busy_o, done_o, err_o, w_load_o, w_row_o, acc_clr_o,
             a_rd_en_o, a_addr_o, a_zero_o, pe_en_o, out_valid_o, drain_col_o
   );

   modport slave (
      input  start_i, abort_i, k_len_i, out_ready_i,
      output busy_o, done_o, err_o, w_load_o, w_row_o, acc_clr_o,
             a_rd_en_o, a_addr_o, a_zero_o, pe_en_o, out_valid_o, drain_col_o
   );
endinterface
`default_nettype wire

// File: rtl/systolic_tile_sequencer.sv
`default_nettype none
// ============================================================================
// systolic_tile_sequencer -- walks one tile through load/clear/stream/flush/drain
// Rev 1.0
// ============================================================================
module systolic_tile_sequencer #(
   parameter int ROWS  = 8,
   parameter int COLS  = 8,
   parameter int K_MAX = 256
) (
   input  logic                             clk,
   input  logic                             rst,
   systolic_tile_sequencer_if.slave         bus
);
   localparam int ROW_W     = ($clog2(ROWS) < 1) ? 1 : $clog2(ROWS);
   localparam int COL_W     = ($clog2(COLS) < 1) ? 1 : $clog2(COLS);
   localparam int ADDR_W    = ($clog2(K_MAX) < 1) ? 1 : $clog2(K_MAX);
   localparam int KLEN_W    = ($clog2(K_MAX + 1) < 1) ? 1 : $clog2(K_MAX + 1);
   localparam int FLUSH_LEN = ROWS + COLS - 2;
   localparam int FLUSH_W   = ($clog2(FLUSH_LEN) < 1) ? 1 : $clog2(FLUSH_LEN);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LOAD_W = 3'd1,
      S_CLEAR  = 3'd2,
      S_STREAM = 3'd3,
      S_FLUSH  = 3'd4,
      S_DRAIN  = 3'd5,
      S_DONE   = 3'd6
   } state_t;

   state_t              state_q;
   logic [KLEN_W-1:0]   k_len_q;
   logic [ROW_W-1:0]    w_row_q;
   logic [ADDR_W-1:0]   a_addr_q;
   logic [FLUSH_W-1:0]  flush_q;
   logic [COL_W-1:0]    drain_col_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;
   logic                w_load_q;
   logic                acc_clr_q;
   logic                a_rd_en_q;
   logic                a_zero_q;
   logic                pe_en_q;
   logic                out_valid_q;

   logic w_k_ok;
   logic w_row_last;
   logic w_addr_last;
   logic w_flush_last;
   logic w_col_last;
   logic w_kill;

   assign w_k_ok       = (bus.k_len_i != '0) && (bus.k_len_i <= KLEN_W'(K_MAX));
   assign w_row_last   = (w_row_q == ROW_W'(ROWS - 1));
   assign w_addr_last  = (KLEN_W'(a_addr_q) == (k_len_q - KLEN_W'(1)));
   assign w_flush_last = (flush_q == FLUSH_W'(FLUSH_LEN - 1));
   assign w_col_last   = (drain_col_q == COL_W'(COLS - 1));
   // abort only bites on a running tile; rst additionally forgets k_len
   assign w_kill       = rst || (bus.abort_i && (state_q != S_IDLE));

   always_ff @(posedge clk) begin
      if (w_kill) begin
         state_q     <= S_IDLE;
         w_row_q     <= '0;
         a_addr_q    <= '0;
         flush_q     <= '0;
         drain_col_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         w_load_q    <= 1'b0;
         acc_clr_q   <= 1'b0;
         a_rd_en_q   <= 1'b0;
         a_zero_q    <= 1'b0;
         pe_en_q     <= 1'b0;
         out_valid_q <= 1'b0;
         if (rst) begin
            k_len_q <= '0;
         end
      end else begin
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         acc_clr_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (bus.start_i) begin
                  if (w_k_ok) begin
                     k_len_q  <= bus.k_len_i;
                     state_q  <= S_LOAD_W;
                     busy_q   <= 1'b1;
                     w_load_q <= 1'b1;
                     w_row_q  <= '0;
                  end else begin
                     err_q <= 1'b1;
                  end
               end
            end
            S_LOAD_W: begin
               if (w_row_last) begin
                  w_row_q   <= '0;
                  w_load_q  <= 1'b0;
                  acc_clr_q <= 1'b1;
                  state_q   <= S_CLEAR;
               end else begin
                  w_row_q <= w_row_q + 1'b1;
               end
            end
            S_CLEAR: begin
               a_addr_q  <= '0;
               a_rd_en_q <= 1'b1;
               pe_en_q   <= 1'b1;
               state_q   <= S_STREAM;
            end
            S_STREAM: begin
               if (w_addr_last) begin
                  a_addr_q  <= '0;
                  a_rd_en_q <= 1'b0;
                  if (FLUSH_LEN == 0) begin
                     pe_en_q     <= 1'b0;
                     out_valid_q <= 1'b1;
                     drain_col_q <= '0;
                     state_q     <= S_DRAIN;
                  end else begin
                     a_zero_q <= 1'b1;
                     flush_q  <= '0;
                     state_q  <= S_FLUSH;
                  end
               end else begin
                  a_addr_q <= a_addr_q + 1'b1;
               end
            end
            S_FLUSH: begin
               if (w_flush_last) begin
                  flush_q     <= '0;
                  a_zero_q    <= 1'b0;
                  pe_en_q     <= 1'b0;
                  out_valid_q <= 1'b1;
                  drain_col_q <= '0;
                  state_q     <= S_DRAIN;
               end else begin
                  flush_q <= flush_q + 1'b1;
               end
            end
            S_DRAIN: begin
               if (bus.out_ready_i) begin
                  if (w_col_last) begin
                     drain_col_q <= '0;
                     out_valid_q <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= S_DONE;
                  end else begin
                     drain_col_q <= drain_col_q + 1'b1;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy_o      = busy_q;
   assign bus.done_o      = done_q;
   assign bus.err_o       = err_q;
   assign bus.w_load_o    = w_load_q;
   assign bus.w_row_o     = w_row_q;
   assign bus.acc_clr_o   = acc_clr_q;
   assign bus.a_rd_en_o   = a_rd_en_q;
   assign bus.a_addr_o    = a_addr_q;
   assign bus.a_zero_o    = a_zero_q;
   assign bus.pe_en_o     = pe_en_q;
   assign bus.out_valid_o = out_valid_q;
   assign bus.drain_col_o = drain_col_q;
endmodule
`default_nettype wire

// File: tb/tb_systolic_tile_sequencer.sv
`default_nettype none
// ============================================================================
// tb_systolic_tile_sequencer -- directed vectors on a 4x4 and a 1x1 sequencer
// Rev 1.0
// ============================================================================
module tb_systolic_tile_sequencer;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   systolic_tile_sequencer_if #(.ROWS(4), .COLS(4), .K_MAX(8)) if4 ();
   systolic_tile_sequencer_if #(.ROWS(1), .COLS(1), .K_MAX(4)) if1 ();

   systolic_tile_sequencer #(.ROWS(4), .COLS(4), .K_MAX(8)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (if4.slave)
   );

   systolic_tile_sequencer #(.ROWS(1), .COLS(1), .K_MAX(4)) u_dut1 (
      .clk (clk),
      .rst (rst),
      .bus (if1.slave)
   );

   typedef struct {
      int k;
      int stall_col;
      int stall_len;
      bit poke;
      int exp_busy;
      bit exp_err;
   } vec_t;

   int n_cmp = 0;
   int n_bad = 0;
   int busy_n, done_n, done_at, err_n, wl_n, clr_n, rd_n, z_n, acc_n, seq_err, hold_err;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic [15:0] outs4();
      return {if4.busy_o, if4.done_o, if4.err_o, if4.w_load_o, if4.w_row_o, if4.acc_clr_o,
              if4.a_rd_en_o, if4.a_addr_o, if4.a_zero_o, if4.pe_en_o, if4.out_valid_o,
              if4.drain_col_o};
   endfunction

   function automatic logic [12:0] outs1();
      return {if1.busy_o, if1.done_o, if1.err_o, if1.w_load_o, if1.w_row_o, if1.acc_clr_o,
              if1.a_rd_en_o, if1.a_addr_o, if1.a_zero_o, if1.pe_en_o, if1.out_valid_o,
              if1.drain_col_o};
   endfunction

   // Called at a falling edge with the 4x4 sequencer idle; runs one tile request.
   task automatic run4(input vec_t v, input string tag);
      int  stall_left;
      bit  stalled;
      bit  poked;
      bit  ready;
      bit  ended;
      busy_n = 0; done_n = 0; done_at = 0; err_n = 0; wl_n = 0; clr_n = 0;
      rd_n = 0; z_n = 0; acc_n = 0; seq_err = 0; hold_err = 0;
      stall_left = v.stall_len;
      stalled    = 1'b0;
      poked      = 1'b0;
      ended      = 1'b0;
      if4.k_len_i = v.k[3:0];
      if4.start_i = 1'b1;
      @(negedge clk);
      if4.start_i = 1'b0;
      for (int cyc = 0; cyc < 300; cyc++) begin
         if (stalled && !(if4.out_valid_o && int'(if4.drain_col_o) == v.stall_col))
            hold_err++;
         if (if4.busy_o) begin
            busy_n++;
            if (if4.done_o) begin
               done_n++;
               done_at = busy_n;
            end
            if (if4.acc_clr_o) clr_n++;
            if (if4.w_load_o) begin
               if (int'(if4.w_row_o) != wl_n) seq_err++;
               wl_n++;
            end
            if (if4.a_rd_en_o) begin
               if (int'(if4.a_addr_o) != rd_n || !if4.pe_en_o) seq_err++;
               rd_n++;
            end
            if (if4.a_zero_o) begin
               if (!if4.pe_en_o || if4.a_rd_en_o) seq_err++;
               z_n++;
            end
            if (if4.out_valid_o && if4.pe_en_o) seq_err++;
         end else if (if4.w_load_o || if4.a_rd_en_o || if4.a_zero_o || if4.out_valid_o ||
                      if4.pe_en_o || if4.done_o) begin
            seq_err++;
         end
         if (if4.err_o) err_n++;
         if (!if4.busy_o && cyc >= 2) begin
            ended = 1'b1;
            break;
         end
         ready   = 1'b1;
         stalled = 1'b0;
         if (if4.out_valid_o && int'(if4.drain_col_o) == v.stall_col && stall_left > 0) begin
            ready   = 1'b0;
            stalled = 1'b1;
            stall_left--;
         end
         if (if4.out_valid_o && ready) begin
            if (int'(if4.drain_col_o) != acc_n) seq_err++;
            acc_n++;
         end
         if4.out_ready_i = ready;
         if4.start_i     = v.poke && (cyc == 1 || (if4.out_valid_o && !poked));
         if (if4.start_i && if4.out_valid_o) poked = 1'b1;
         @(negedge clk);
      end
      if4.out_ready_i = 1'b1;
      if4.start_i     = 1'b0;
      check({tag, "_end"},       int'(ended), 1);
      check({tag, "_busy"},      busy_n,   v.exp_busy);
      check({tag, "_done"},      done_n,   v.exp_err ? 0 : 1);
      check({tag, "_done_last"}, done_at,  v.exp_busy);
      check({tag, "_err"},       err_n,    v.exp_err ? 1 : 0);
      check({tag, "_w_load"},    wl_n,     v.exp_err ? 0 : 4);
      check({tag, "_acc_clr"},   clr_n,    v.exp_err ? 0 : 1);
      check({tag, "_a_rd"},      rd_n,     v.exp_err ? 0 : v.k);
      check({tag, "_a_zero"},    z_n,      v.exp_err ? 0 : 6);
      check({tag, "_drained"},   acc_n,    v.exp_err ? 0 : 4);
      check({tag, "_order"},     seq_err,  0);
      check({tag, "_hold"},      hold_err, 0);
      if (v.poke) begin
         @(negedge clk);
         check({tag, "_not_queued"}, int'(if4.busy_o), 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[8];
      vec_t v;
      bit   found;
      int   q, b, z, d, w, a;

      vecs[0] = '{3, -1, 0, 1'b0, 19, 1'b0};
      vecs[1] = '{3,  2, 5, 1'b0, 24, 1'b0};
      vecs[2] = '{0, -1, 0, 1'b0,  0, 1'b1};
      vecs[3] = '{9, -1, 0, 1'b0,  0, 1'b1};
      vecs[4] = '{8, -1, 0, 1'b1, 24, 1'b0};
      vecs[5] = '{1, -1, 0, 1'b0, 17, 1'b0};
      vecs[6] = '{2,  0, 2, 1'b0, 20, 1'b0};
      vecs[7] = '{1,  3, 1, 1'b0, 18, 1'b0};

      if4.start_i = 1'b0; if4.abort_i = 1'b0; if4.k_len_i = '0; if4.out_ready_i = 1'b1;
      if1.start_i = 1'b0; if1.abort_i = 1'b0; if1.k_len_i = '0; if1.out_ready_i = 1'b1;

      repeat (3) @(negedge clk);
      check("reset_outs4", int'(outs4()), 0);
      check("reset_outs1", int'(outs1()), 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_outs4", int'(outs4()), 0);

      for (int i = 0; i < 8; i++) begin
         run4(vecs[i], $sformatf("vec%0d", i));
      end

      // abort while streaming, once address 1 is being read
      if4.k_len_i = 4'd5;
      if4.start_i = 1'b1;
      @(negedge clk);
      if4.start_i = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
         if (if4.a_rd_en_o && if4.a_addr_o == 3'd1) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("abort_reach", int'(found), 1);
      if4.abort_i = 1'b1;
      @(negedge clk);
      if4.abort_i = 1'b0;
      check("abort_outs", int'(outs4()), 0);
      q = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         q += int'(if4.done_o) + int'(if4.err_o) + int'(if4.busy_o);
      end
      check("abort_quiet", q, 0);
      v = '{2, -1, 0, 1'b0, 18, 1'b0};
      run4(v, "post_abort");

      // reset while draining under backpressure
      if4.k_len_i = 4'd1;
      if4.start_i = 1'b1;
      @(negedge clk);
      if4.start_i = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 60; c++) begin
         if (if4.out_valid_o) begin
            found = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("rst_reach_drain", int'(found), 1);
      if4.out_ready_i = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      check("rst_drain_outs", int'(outs4()), 0);
      rst = 1'b0;
      if4.out_ready_i = 1'b1;
      @(negedge clk);
      check("rst_drain_idle", int'(outs4()), 0);
      v = '{3, -1, 0, 1'b0, 19, 1'b0};
      run4(v, "post_rst");

      // 1x1 array: no flush phase
      if1.k_len_i = 3'd2;
      if1.start_i = 1'b1;
      @(negedge clk);
      if1.start_i = 1'b0;
      b = 0; z = 0; d = 0; w = 0; a = 0;
      for (int c = 0; c < 40; c++) begin
         if (!if1.busy_o) break;
         b++;
         z += int'(if1.a_zero_o);
         d += int'(if1.done_o);
         w += int'(if1.w_load_o);
         a += int'(if1.out_valid_o);
         @(negedge clk);
      end
      check("one_busy",    b, 6);
      check("one_a_zero",  z, 0);
      check("one_done",    d, 1);
      check("one_w_load",  w, 1);
      check("one_drained", a, 1);
      check("one_idle",    int'(outs1()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
`default_nettype wire
